// File: rtl/wrr_arb_pkg.sv
// Shared types and constants for the weighted round-robin arbiter.
// The optional weighted-quantum feature is selected by the WRR_ARB_WEIGHT_EN macro.
package wrr_arb_pkg;

  localparam int DEF_N_REQ = 16;
  localparam int DEF_WGT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/wrr_arb_n_if.sv
// Request/grant bundle between the per-queue request flags, the arbiter and the TX consumer.
// slave = arbiter side, master = requester/consumer side.
interface wrr_arb_n_if
  import wrr_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WGT_W = DEF_WGT_W,
  parameter int IDX_W = clog2(N_REQ)
);

  logic                   arb_ena;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WGT_W-1:0] weight;
  logic                   gnt_ready;
  logic                   gnt_valid;
  logic [N_REQ-1:0]       gnt_onehot;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   gnt_last;

  modport slave (
    input  arb_ena, req, weight, gnt_ready,
    output gnt_valid, gnt_onehot, gnt_idx, gnt_last
  );

  modport master (
    output arb_ena, req, weight, gnt_ready,
    input  gnt_valid, gnt_onehot, gnt_idx, gnt_last
  );

endinterface

// File: rtl/wrr_arb_n_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot winner, its binary index and an any-set flag.
module prio_enc_n
  import wrr_arb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    onehot = req & (~req + N_REQ'(1));
    any    = |req;
    idx    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/wrr_arb_n.sv
// N-way weighted round-robin arbiter with valid/ready grant handshake, hold under back-pressure
// and request withdrawal. Define WRR_ARB_WEIGHT_EN to enable per-requester beat quanta.
module wrr_arb_n
  import wrr_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WGT_W = DEF_WGT_W
) (
  input logic        sys_clk,
  input logic        sys_rst,
  wrr_arb_n_if.slave arb_if
);

  localparam int IDX_W = clog2(N_REQ);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
`ifdef WRR_ARB_WEIGHT_EN
  logic [WGT_W-1:0] credit_q, credit_d;
  logic [WGT_W-1:0] load_credit;
`endif

  logic             gnt_valid;
  logic             xfer;
  logic             last_beat;
  logic             rel;
  logic [N_REQ-1:0] holder_oh;
  logic [N_REQ-1:0] pick_req;
  logic [N_REQ-1:0] pick_mask;
  logic [IDX_W-1:0] pick_ptr;

  logic [N_REQ-1:0] m_oh, u_oh;
  logic [IDX_W-1:0] m_idx, u_idx;
  logic             m_any, u_any;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;

  // On release the holder is excluded and the rotation pointer advances in the same cycle,
  // so the next winner can be loaded without a bubble.
  always_comb begin
    gnt_valid = (state_q == GRANT);
    holder_oh = N_REQ'(1) << gnt_idx_q;
    xfer      = gnt_valid && arb_if.gnt_ready;
`ifdef WRR_ARB_WEIGHT_EN
    last_beat = xfer && (credit_q == WGT_W'(1));
`else
    last_beat = xfer;
`endif
    rel       = gnt_valid && (last_beat || !arb_if.req[gnt_idx_q]);
    pick_req  = rel ? (arb_if.req & ~holder_oh) : arb_if.req;
    pick_ptr  = rel ? gnt_idx_q : last_ptr_q;
    pick_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pick_mask[i] = (IDX_W'(i) > pick_ptr);
    end
  end

  prio_enc_n #(.N_REQ(N_REQ)) u_enc_masked (
    .req    (pick_req & pick_mask),
    .onehot (m_oh),
    .idx    (m_idx),
    .any    (m_any)
  );

  prio_enc_n #(.N_REQ(N_REQ)) u_enc_unmasked (
    .req    (pick_req),
    .onehot (u_oh),
    .idx    (u_idx),
    .any    (u_any)
  );

  assign win_idx = m_any ? m_idx : u_idx;
  assign win_any = u_any;

  logic unused_oh;
  assign unused_oh = ^{m_oh, u_oh};

`ifdef WRR_ARB_WEIGHT_EN
  // A zero weight still earns one beat so the credit counter can never underflow.
  always_comb begin
    load_credit = arb_if.weight[win_idx*WGT_W +: WGT_W];
    if (load_credit == '0) load_credit = WGT_W'(1);
  end
`else
  logic unused_weight;
  assign unused_weight = ^arb_if.weight;
`endif

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_ptr_d = last_ptr_q;
`ifdef WRR_ARB_WEIGHT_EN
    credit_d   = credit_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (arb_if.arb_ena && win_any) begin
          state_d   = GRANT;
          gnt_idx_d = win_idx;
`ifdef WRR_ARB_WEIGHT_EN
          credit_d  = load_credit;
`endif
        end
      end
      GRANT: begin
`ifdef WRR_ARB_WEIGHT_EN
        if (xfer) credit_d = credit_q - WGT_W'(1);
`endif
        if (rel) begin
          last_ptr_d = gnt_idx_q;
          if (arb_if.arb_ena && win_any) begin
            gnt_idx_d = win_idx;
`ifdef WRR_ARB_WEIGHT_EN
            credit_d  = load_credit;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      gnt_idx_q  <= '0;
      last_ptr_q <= IDX_W'(N_REQ - 1);
`ifdef WRR_ARB_WEIGHT_EN
      credit_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_ptr_q <= last_ptr_d;
`ifdef WRR_ARB_WEIGHT_EN
      credit_q   <= credit_d;
`endif
    end
  end

  always_comb begin
    arb_if.gnt_valid  = gnt_valid;
    arb_if.gnt_idx    = gnt_idx_q;
    arb_if.gnt_onehot = gnt_valid ? holder_oh : '0;
`ifdef WRR_ARB_WEIGHT_EN
    arb_if.gnt_last   = gnt_valid && (credit_q == WGT_W'(1));
`else
    arb_if.gnt_last   = gnt_valid;
`endif
  end

endmodule

// File: tb/tb_wrr_arb_n.sv
// Self-checking bench for wrr_arb_n (N_REQ=4, WGT_W=4): round-robin scan model plus directed literals.
// Expectations follow WRR_ARB_WEIGHT_EN when the bench is built with the same macro as the RTL.
module tb_wrr_arb_n;

  localparam int N = 4;
  localparam int W = 4;

  logic sys_clk;
  logic sys_rst;

  wrr_arb_n_if #(.N_REQ(N), .WGT_W(W)) arb_if ();

  wrr_arb_n #(.N_REQ(N), .WGT_W(W)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .arb_if  (arb_if)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a granted requester owns the bus for quantum accepted beats, then the next
  // requester is found by scanning upward from the previous holder with wrap-around.
  bit         m_valid = 1'b0;
  int         m_idx   = 0;
  int         m_left  = 0;
  int         m_ptr   = N - 1;
  logic [N-1:0] m_r;

  function automatic int quantum(input int w);
`ifdef WRR_ARB_WEIGHT_EN
    return (w == 0) ? 1 : w;
`else
    return 1;
`endif
  endfunction

  function automatic int rr_next(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic m_load(input int w);
    m_valid = 1'b1;
    m_idx   = w;
    m_left  = quantum(int'(arb_if.weight[w*W +: W]));
  endtask

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_left  = 0;
      m_ptr   = N - 1;
    end else if (!m_valid) begin
      if (arb_if.arb_ena && arb_if.req != '0) m_load(rr_next(arb_if.req, m_ptr));
    end else begin
      if (arb_if.gnt_ready) m_left--;
      if ((arb_if.gnt_ready && m_left == 0) || !arb_if.req[m_idx]) begin
        m_ptr = m_idx;
        m_r = arb_if.req;
        m_r[m_idx] = 1'b0;
        if (arb_if.arb_ena && m_r != '0) m_load(rr_next(m_r, m_ptr));
        else m_valid = 1'b0;
      end
    end
  end

  always @(negedge sys_clk) begin
    check("m_valid", 32'(arb_if.gnt_valid), 32'(m_valid));
    check("m_onehot", 32'(arb_if.gnt_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
    if (m_valid) check("m_idx", 32'(arb_if.gnt_idx), 32'(m_idx));
    check("m_last", 32'(arb_if.gnt_last), 32'(m_valid && m_left == 1));
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_gnt(input string name, input int idx, input bit last);
    check({name, "_valid"}, 32'(arb_if.gnt_valid), 32'd1);
    check({name, "_idx"}, 32'(arb_if.gnt_idx), 32'(idx));
    check({name, "_last"}, 32'(arb_if.gnt_last), 32'(last));
  endtask

  int rr_seq [7] = '{1, 2, 3, 0, 1, 2, 3};
`ifdef WRR_ARB_WEIGHT_EN
  int wt_idx  [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  bit wt_last [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
`else
  int wt_idx  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  bit wt_last [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
  int z_idx [4] = '{0, 1, 0, 1};

  initial begin
    sys_rst          = 1'b1;
    arb_if.arb_ena   = 1'b0;
    arb_if.req       = '0;
    arb_if.gnt_ready = 1'b0;
    arb_if.weight    = 16'h1111;
    tick();
    tick();
    check("rst_valid", 32'(arb_if.gnt_valid), 32'd0);
    check("rst_onehot", 32'(arb_if.gnt_onehot), 32'd0);
    check("rst_idx", 32'(arb_if.gnt_idx), 32'd0);
    check("rst_last", 32'(arb_if.gnt_last), 32'd0);
    sys_rst = 1'b0;

    // Reset mid-grant drops the grant without waiting for a clock edge.
    arb_if.arb_ena = 1'b1;
    arb_if.req     = 4'b0100;
    tick();
    expect_gnt("pre_rst", 2, 1'b1);
    #2 sys_rst = 1'b1;
    #1;
    check("midrst_valid", 32'(arb_if.gnt_valid), 32'd0);
    check("midrst_onehot", 32'(arb_if.gnt_onehot), 32'd0);
    tick();
    sys_rst    = 1'b0;
    arb_if.req = 4'b1111;
    tick();
    expect_gnt("post_rst", 0, 1'b1);
    check("post_rst_onehot", 32'(arb_if.gnt_onehot), 32'h1);

    // Plain rotation with unit weights; ends with arb_ena low at release.
    arb_if.gnt_ready = 1'b1;
    foreach (rr_seq[i]) begin
      tick();
      expect_gnt("rr", rr_seq[i], 1'b1);
    end
    arb_if.arb_ena = 1'b0;
    tick();
    check("rr_stop_valid", 32'(arb_if.gnt_valid), 32'd0);

    // Weighted quanta: weight0=3, weight1=1.
    arb_if.weight  = 16'h1113;
    arb_if.req     = 4'b0011;
    arb_if.arb_ena = 1'b1;
    foreach (wt_idx[i]) begin
      tick();
      expect_gnt("wt", wt_idx[i], wt_last[i]);
    end

    // Zero weight yields a single-beat quantum.
    arb_if.weight = 16'h1110;
    foreach (z_idx[i]) begin
      tick();
      expect_gnt("w0", z_idx[i], 1'b1);
    end

    // Back-pressure on requester 1 with weight 2.
    arb_if.weight = 16'h1120;
    arb_if.req    = 4'b0010;
    tick();
    check("bp_gap_valid", 32'(arb_if.gnt_valid), 32'd0);
    arb_if.gnt_ready = 1'b0;
    tick();
`ifdef WRR_ARB_WEIGHT_EN
    expect_gnt("bp_load", 1, 1'b0);
`else
    expect_gnt("bp_load", 1, 1'b1);
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_idx", 32'(arb_if.gnt_idx), 32'd1);
      check("bp_hold_onehot", 32'(arb_if.gnt_onehot), 32'h2);
    end
    arb_if.gnt_ready = 1'b1;
    tick();
`ifdef WRR_ARB_WEIGHT_EN
    expect_gnt("bp_beat1", 1, 1'b1);
    tick();
    check("bp_release_valid", 32'(arb_if.gnt_valid), 32'd0);
`else
    check("bp_release_valid", 32'(arb_if.gnt_valid), 32'd0);
    tick();
`endif
    arb_if.req = '0;
    tick();
    tick();
    check("bp_idle_valid", 32'(arb_if.gnt_valid), 32'd0);

    // Withdrawal by holder 3 with only requester 0 left: pointer wraps to 0.
    arb_if.weight    = 16'h3120;
    arb_if.req       = 4'b1000;
    arb_if.gnt_ready = 1'b0;
    tick();
    tick();
    check("wd_hold_idx", 32'(arb_if.gnt_idx), 32'd3);
    arb_if.req = 4'b0001;
    tick();
    expect_gnt("wd_wrap", 0, 1'b1);
    arb_if.arb_ena   = 1'b0;
    arb_if.gnt_ready = 1'b1;
    tick();
    check("wd_ena_off_valid", 32'(arb_if.gnt_valid), 32'd0);

    // A held grant completes its quantum even after arb_ena drops.
    arb_if.weight    = 16'h3220;
    arb_if.arb_ena   = 1'b1;
    arb_if.req       = 4'b0100;
    arb_if.gnt_ready = 1'b0;
    tick();
    check("ena_hold_idx", 32'(arb_if.gnt_idx), 32'd2);
    arb_if.arb_ena   = 1'b0;
    arb_if.gnt_ready = 1'b1;
    tick();
`ifdef WRR_ARB_WEIGHT_EN
    expect_gnt("ena_hold_beat", 2, 1'b1);
`else
    check("ena_hold_done", 32'(arb_if.gnt_valid), 32'd0);
`endif
    tick();
    check("ena_hold_end", 32'(arb_if.gnt_valid), 32'd0);

    arb_if.req = '0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
